// File: rtl/alu_arb.sv
// Round-robin arbiter and sequencer that shares one single-cycle ALU between two requesters.
// It registers the granted op and operands, captures the result, and holds it until the owner accepts.
module alu_arb #(
  parameter int unsigned DW  = 32,
  parameter int unsigned OPW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  // Port 0: integer execute path
  input  logic           req0_valid_i,
  output logic           req0_ready_o,
  input  logic [OPW-1:0] req0_op_i,
  input  logic [DW-1:0]  req0_src1_i,
  input  logic [DW-1:0]  req0_src2_i,
  output logic           rsp0_valid_o,
  input  logic           rsp0_ready_i,
  // Port 1: branch/compare path
  input  logic           req1_valid_i,
  output logic           req1_ready_o,
  input  logic [OPW-1:0] req1_op_i,
  input  logic [DW-1:0]  req1_src1_i,
  input  logic [DW-1:0]  req1_src2_i,
  output logic           rsp1_valid_o,
  input  logic           rsp1_ready_i,
  // Shared response data
  output logic [DW-1:0]  rsp_res_o,
  output logic           rsp_zero_o,
  // ALU interface
  output logic [OPW-1:0] alu_op_o,
  output logic [DW-1:0]  alu_src1_o,
  output logic [DW-1:0]  alu_src2_o,
  input  logic [DW-1:0]  alu_res_i,
  input  logic           alu_zero_i,
  output logic           busy_o
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           last_gnt_q, last_gnt_d;
  logic           owner_q, owner_d;
  logic [OPW-1:0] op_q, op_d;
  logic [DW-1:0]  src1_q, src1_d;
  logic [DW-1:0]  src2_q, src2_d;
  logic [DW-1:0]  res_q, res_d;
  logic           zero_q, zero_d;

  logic grant0, grant1;
  logic in_idle;
  logic owner_ack;

  assign in_idle = (state_q == StIdle);

  // The port not granted last wins a tie; a lone requester always wins.
  assign grant0 = req0_valid_i & (~req1_valid_i | last_gnt_q);
  assign grant1 = req1_valid_i & (~req0_valid_i | ~last_gnt_q);

  assign req0_ready_o = in_idle & grant0;
  assign req1_ready_o = in_idle & grant1;

  assign owner_ack = owner_q ? rsp1_ready_i : rsp0_ready_i;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    owner_d    = owner_q;
    op_d       = op_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    res_d      = res_q;
    zero_d     = zero_q;

    case (state_q)
      StIdle: begin
        if (req0_valid_i && req0_ready_o) begin
          op_d       = req0_op_i;
          src1_d     = req0_src1_i;
          src2_d     = req0_src2_i;
          owner_d    = 1'b0;
          last_gnt_d = 1'b0;
          state_d    = StExec;
        end else if (req1_valid_i && req1_ready_o) begin
          op_d       = req1_op_i;
          src1_d     = req1_src1_i;
          src2_d     = req1_src2_i;
          owner_d    = 1'b1;
          last_gnt_d = 1'b1;
          state_d    = StExec;
        end
      end
      StExec: begin
        res_d   = alu_res_i;
        zero_d  = alu_zero_i;
        state_d = StResp;
      end
      StResp: begin
        if (owner_ack) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      last_gnt_q <= 1'b1;
      owner_q    <= 1'b0;
      op_q       <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      res_q      <= '0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      owner_q    <= owner_d;
      op_q       <= op_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      res_q      <= res_d;
      zero_q     <= zero_d;
    end
  end

  // ALU inputs come only from the operand registers, never from the request ports.
  assign alu_op_o   = op_q;
  assign alu_src1_o = src1_q;
  assign alu_src2_o = src2_q;

  assign rsp_res_o    = res_q;
  assign rsp_zero_o   = zero_q;
  assign rsp0_valid_o = (state_q == StResp) & ~owner_q;
  assign rsp1_valid_o = (state_q == StResp) & owner_q;
  assign busy_o       = ~in_idle;

endmodule

// File: tb/tb_alu_arb.sv
// Directed bench for alu_arb with a small behavioural ALU attached to its ALU port.
module tb_alu_arb;

  localparam int unsigned DW  = 32;
  localparam int unsigned OPW = 4;

  localparam logic [OPW-1:0] OpAdd  = 4'd0;
  localparam logic [OPW-1:0] OpSub  = 4'd1;
  localparam logic [OPW-1:0] OpSltu = 4'd2;
  localparam logic [OPW-1:0] OpXor  = 4'd3;
  localparam logic [OPW-1:0] OpSll  = 4'd4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic           req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [OPW-1:0] req0_op, req1_op, alu_op;
  logic [DW-1:0]  req0_src1, req0_src2, req1_src1, req1_src2;
  logic [DW-1:0]  rsp_res, alu_src1, alu_src2, alu_res;
  logic           rsp_zero, alu_zero, busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_arb #(.DW(DW), .OPW(OPW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid_i (req0_valid),
    .req0_ready_o (req0_ready),
    .req0_op_i    (req0_op),
    .req0_src1_i  (req0_src1),
    .req0_src2_i  (req0_src2),
    .rsp0_valid_o (rsp0_valid),
    .rsp0_ready_i (rsp0_ready),
    .req1_valid_i (req1_valid),
    .req1_ready_o (req1_ready),
    .req1_op_i    (req1_op),
    .req1_src1_i  (req1_src1),
    .req1_src2_i  (req1_src2),
    .rsp1_valid_o (rsp1_valid),
    .rsp1_ready_i (rsp1_ready),
    .rsp_res_o    (rsp_res),
    .rsp_zero_o   (rsp_zero),
    .alu_op_o     (alu_op),
    .alu_src1_o   (alu_src1),
    .alu_src2_o   (alu_src2),
    .alu_res_i    (alu_res),
    .alu_zero_i   (alu_zero),
    .busy_o       (busy)
  );

  // Stand-in ALU
  always_comb begin
    alu_res = '0;
    case (alu_op)
      OpAdd:   alu_res = alu_src1 + alu_src2;
      OpSub:   alu_res = alu_src1 - alu_src2;
      OpSltu:  alu_res = {31'd0, alu_src1 < alu_src2};
      OpXor:   alu_res = alu_src1 ^ alu_src2;
      OpSll:   alu_res = alu_src1 << alu_src2[4:0];
      default: alu_res = '0;
    endcase
    alu_zero = (alu_res == '0);
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance past the next rising edge; leaves time to drive inputs and settle before checks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_reset(input string tag);
    check({tag, " busy"}, {31'd0, busy}, 32'd0);
    check({tag, " rsp0_valid"}, {31'd0, rsp0_valid}, 32'd0);
    check({tag, " rsp1_valid"}, {31'd0, rsp1_valid}, 32'd0);
    check({tag, " rsp_res"}, rsp_res, 32'd0);
    check({tag, " rsp_zero"}, {31'd0, rsp_zero}, 32'd0);
    check({tag, " alu_op"}, {28'd0, alu_op}, 32'd0);
    check({tag, " alu_src1"}, alu_src1, 32'd0);
    check({tag, " alu_src2"}, alu_src2, 32'd0);
  endtask

  initial begin
    req0_valid = 1'b0; req0_op = '0; req0_src1 = '0; req0_src2 = '0; rsp0_ready = 1'b0;
    req1_valid = 1'b0; req1_op = '0; req1_src1 = '0; req1_src2 = '0; rsp1_ready = 1'b0;

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    check_outputs_reset("reset");
    check("reset req0_ready idle", {31'd0, req0_ready}, 32'd0);
    tick();
    tick();
    #2 rst_n = 1'b1;

    // Single op on port 0, with operand isolation during EXEC
    tick();
    req0_valid = 1'b1; req0_op = OpAdd; req0_src1 = 32'd5; req0_src2 = 32'd7;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    check("single req0_ready", {31'd0, req0_ready}, 32'd1);
    check("single req1_ready", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0; req0_src1 = 32'd99;
    #1;
    check("exec busy", {31'd0, busy}, 32'd1);
    check("exec alu_src1 isolated", alu_src1, 32'd5);
    check("exec alu_src2", alu_src2, 32'd7);
    check("exec req0_ready", {31'd0, req0_ready}, 32'd0);
    tick();
    check("single rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    check("single rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("single rsp_res", rsp_res, 32'd12);
    check("single rsp_zero", {31'd0, rsp_zero}, 32'd0);
    tick();
    check("single back idle", {31'd0, busy}, 32'd0);
    check("single rsp0_valid drop", {31'd0, rsp0_valid}, 32'd0);

    // Lone requester: port 0 again, granted despite being last granted
    req0_valid = 1'b1; req0_op = OpSub; req0_src1 = 32'd9; req0_src2 = 32'd9;
    #1;
    check("lone req0_ready", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    tick();
    check("lone rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    check("lone rsp_res", rsp_res, 32'd0);
    check("lone rsp_zero", {31'd0, rsp_zero}, 32'd1);
    tick();

    // Reset in the middle of an SLL on port 1
    req1_valid = 1'b1; req1_op = OpSll; req1_src1 = 32'd1; req1_src2 = 32'd4;
    #1;
    check("sll req1_ready", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    #1;
    check("sll exec alu_src2", alu_src2, 32'd4);
    rst_n = 1'b0;
    #1;
    check_outputs_reset("midop");
    tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post reset rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
      check("post reset rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    end

    // Contention: both valid continuously, grants alternate starting with port 0
    req0_valid = 1'b1; req0_op = OpSub;  req0_src1 = 32'd9; req0_src2 = 32'd9;
    req1_valid = 1'b1; req1_op = OpSltu; req1_src1 = 32'd3; req1_src2 = 32'd8;
    for (int k = 0; k < 4; k++) begin
      logic exp_p1;
      exp_p1 = (k % 2) == 1;
      #1;
      check("contend req0_ready", {31'd0, req0_ready}, {31'd0, ~exp_p1});
      check("contend req1_ready", {31'd0, req1_ready}, {31'd0, exp_p1});
      tick();
      tick();
      check("contend rsp0_valid", {31'd0, rsp0_valid}, {31'd0, ~exp_p1});
      check("contend rsp1_valid", {31'd0, rsp1_valid}, {31'd0, exp_p1});
      check("contend rsp_res", rsp_res, exp_p1 ? 32'd1 : 32'd0);
      check("contend rsp_zero", {31'd0, rsp_zero}, exp_p1 ? 32'd0 : 32'd1);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Backpressure on port 1 while port 0 waits
    req1_valid = 1'b1; req1_op = OpXor; req1_src1 = 32'h0000_F0F0; req1_src2 = 32'h0000_0FF0;
    rsp1_ready = 1'b0;
    #1;
    check("bp req1_ready", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = OpAdd; req0_src1 = 32'd1; req0_src2 = 32'd2;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
      check("bp rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
      check("bp rsp_res", rsp_res, 32'h0000_FF00);
      check("bp busy", {31'd0, busy}, 32'd1);
      check("bp req0_ready", {31'd0, req0_ready}, 32'd0);
      tick();
    end
    rsp1_ready = 1'b1;
    tick();
    check("bp released idle", {31'd0, busy}, 32'd0);
    check("bp req0 granted", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    tick();
    check("bp port0 rsp_res", rsp_res, 32'd3);
    check("bp port0 rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
